// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding, default width and counter sizing for the serial subtractor
package serial_subtractor_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter only needs to reach WIDTH-1; keep at least one bit for tiny widths.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B subtractor, one bit per clock, start/ready/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT,
    output logic             OVF,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             fs_d;
    logic             fs_bout;

    full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        ready_d  = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d   = A;
                    b_sr_d   = B;
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Result fills from the MSB end, so after WIDTH shifts bit 0 lands in place.
                res_d    = {fs_d, res_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = fs_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {fs_d, res_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready = ready_q;
    assign DIFF  = diff_q;
    assign BOUT  = bout_q;
    assign OVF   = ovf_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with directed and random operands
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        int         due_cyc;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_done_cyc = -1;
    int   done_count = 0;
    exp_t exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .ready (ready),
        .DIFF  (diff),
        .BOUT  (bout),
        .OVF   (ovf),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int due);
        exp_t e;
        int   sd;
        sd        = $signed(a) - $signed(b);
        e.due_cyc = due;
        e.diff    = 8'((int'(a) - int'(b) + 256) % 256);
        e.bout    = (a < b);
        e.ovf     = (sd > 127) || (sd < -128);
        return e;
    endfunction

    // Waits for an idle cycle, presents the operands and returns the accepting edge index.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            acc = -1;
            return;
        end
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        exp_q.push_back(model(a, b, acc + W));
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            done_count++;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", 32'(cyc), 32'(e.due_cyc));
                chk("diff", 32'(diff), 32'(e.diff));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("ready_in_done", 32'(ready), 32'd1);
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int acc2;
        int prev_done;
        int dc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        issue(8'h01, 8'h01, acc);
        @(negedge clk);
        chk("busy_ready", 32'(ready), 32'd0);
        wait_drain();

        issue(8'hAA, 8'h55, acc);
        issue(8'h00, 8'h01, acc2);
        chk("b2b_accept", 32'(acc2), 32'(acc + W + 1));
        wait_drain();

        issue(8'h80, 8'h80, acc);
        issue(8'h7F, 8'hFF, acc2);
        // Previous result must be held while the next operation is in flight.
        @(negedge clk);
        chk("hold_diff", 32'(diff), 32'h00);
        wait_drain();

        dc = done_count;
        issue(8'h10, 8'h01, acc);
        @(negedge clk);
        start = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 8'h3C; b_in = 8'hC3;
        wait_drain();
        repeat (W + 2) @(negedge clk);
        chk("ignored_done_once", 32'(done_count - dc), 32'd1);

        dc = done_count;
        issue(8'h05, 8'h03, acc);
        repeat (4) @(negedge clk);
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        repeat (W + 2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        issue(8'h05, 8'h03, acc);
        wait_drain();
        chk("abort_done_count", 32'(done_count - dc), 32'd1);

        prev_done = last_done_cyc;
        for (int i = 0; i < 1000; i++) begin
            issue(8'($urandom), 8'($urandom), acc);
        end
        wait_drain();
        chk("sweep_done", 32'(last_done_cyc > prev_done), 32'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
